led_ring_scheduler: RTL and testbench

- Collects per-zone colours from the four edge extractors (top, bottom, left, right) and stores them in ring order in a ping-pong zone buffer.
- At each frame end, validates and commits the frame, then sequences the stored zones out to the single LED serialiser over a valid/ready handshake, followed by a latch gap.
- Sits between the edge-extraction blocks and the LED driver.
- Is the only block that decides which frame is shown and which frames are dropped.

---
 rtl/led_ring_scheduler.sv | 177 +++++++++++++++++
 tb/tb_led_ring_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ring_scheduler.sv
// Collects edge-zone colours into a ping-pong ring buffer and, on each valid frame commit,
// streams the ring out to the LED serialiser followed by a latch gap.
module led_ring_scheduler #(
    parameter int unsigned NUM_HOR    = 78,
    parameter int unsigned NUM_VER    = 44,
    parameter int unsigned GAP_CYCLES = 8000
) (
    input  logic        clkn,
    input  logic        reset,
    input  logic        vs,
    input  logic        up_dv,
    input  logic [23:0] up_data,
    input  logic        down_dv,
    input  logic [23:0] down_data,
    input  logic        left_dv,
    input  logic [23:0] left_data,
    input  logic        right_dv,
    input  logic [23:0] right_data,
    input  logic        led_ready,
    output logic        led_valid,
    output logic [23:0] led_data,
    output logic        led_last,
    output logic        busy,
    output logic        frame_drop,
    output logic        frame_err
);
    localparam int unsigned N  = 2 * NUM_HOR + 2 * NUM_VER;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    localparam logic [AW-1:0] HOR_LIM    = AW'(NUM_HOR);
    localparam logic [AW-1:0] VER_LIM    = AW'(NUM_VER);
    localparam logic [AW-1:0] RIGHT_BASE = AW'(NUM_HOR);
    localparam logic [AW-1:0] BOT_BASE   = AW'(2 * NUM_HOR + NUM_VER - 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          r_state;
    logic            r_vs;
    logic            r_ovf;
    logic            r_wr_bank;
    logic [AW-1:0]   r_cnt_top;
    logic [AW-1:0]   r_cnt_right;
    logic [AW-1:0]   r_cnt_bot;
    logic [AW-1:0]   r_cnt_left;
    logic [AW-1:0]   r_rd_addr;
    logic [GW-1:0]   r_gap;
    logic [23:0]     r_mem [2][N];

    logic            w_rise;
    logic            w_fall;
    logic            w_top_we;
    logic            w_right_we;
    logic            w_bot_we;
    logic            w_left_we;
    logic            w_ovf_hit;
    logic            w_frame_ok;
    logic            w_rd_bank;
    logic [AW-1:0]   w_right_addr;
    logic [AW-1:0]   w_bot_addr;
    logic [AW-1:0]   w_left_addr;
    logic [AW-1:0]   w_next_addr;

    assign w_rise = vs & ~r_vs;
    assign w_fall = ~vs & r_vs;

    assign w_top_we   = up_dv    & ~vs & (r_cnt_top   < HOR_LIM);
    assign w_right_we = right_dv & ~vs & (r_cnt_right < VER_LIM);
    assign w_bot_we   = down_dv  & ~vs & (r_cnt_bot   < HOR_LIM);
    assign w_left_we  = left_dv  & ~vs & (r_cnt_left  < VER_LIM);

    // Counters saturate at their limit, so "at the limit" is an equality test.
    assign w_ovf_hit = ~vs & ((up_dv    & (r_cnt_top   == HOR_LIM)) |
                              (right_dv & (r_cnt_right == VER_LIM)) |
                              (down_dv  & (r_cnt_bot   == HOR_LIM)) |
                              (left_dv  & (r_cnt_left  == VER_LIM)));

    assign w_frame_ok = (r_cnt_top == HOR_LIM) && (r_cnt_right == VER_LIM) &&
                        (r_cnt_bot == HOR_LIM) && (r_cnt_left == VER_LIM) && !r_ovf;

    assign w_right_addr = RIGHT_BASE + r_cnt_right;
    assign w_bot_addr   = BOT_BASE - r_cnt_bot;
    assign w_left_addr  = LAST_ADDR - r_cnt_left;
    assign w_rd_bank    = ~r_wr_bank;
    assign w_next_addr  = r_rd_addr + AW'(1);

    assign busy = (r_state != StIdle);

    // The four edges map to disjoint address ranges, so all four may write in one cycle.
    always_ff @(negedge clkn) begin
        if (w_top_we)   r_mem[r_wr_bank][r_cnt_top]   <= up_data;
        if (w_right_we) r_mem[r_wr_bank][w_right_addr] <= right_data;
        if (w_bot_we)   r_mem[r_wr_bank][w_bot_addr]   <= down_data;
        if (w_left_we)  r_mem[r_wr_bank][w_left_addr]  <= left_data;
    end

    // Reset r_vs high so a low vs after reset is seen as a frame start, not a commit.
    always_ff @(negedge clkn or posedge reset) begin
        if (reset) begin
            r_vs        <= 1'b1;
            r_ovf       <= 1'b0;
            r_cnt_top   <= '0;
            r_cnt_right <= '0;
            r_cnt_bot   <= '0;
            r_cnt_left  <= '0;
        end else begin
            r_vs <= vs;
            if (w_rise || w_fall) begin
                r_ovf       <= 1'b0;
                r_cnt_top   <= '0;
                r_cnt_right <= '0;
                r_cnt_bot   <= '0;
                r_cnt_left  <= '0;
            end else begin
                r_ovf <= r_ovf | w_ovf_hit;
                if (w_top_we)   r_cnt_top   <= r_cnt_top   + AW'(1);
                if (w_right_we) r_cnt_right <= r_cnt_right + AW'(1);
                if (w_bot_we)   r_cnt_bot   <= r_cnt_bot   + AW'(1);
                if (w_left_we)  r_cnt_left  <= r_cnt_left  + AW'(1);
            end
        end
    end

    always_ff @(negedge clkn or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_wr_bank  <= 1'b0;
            r_rd_addr  <= '0;
            r_gap      <= '0;
            led_valid  <= 1'b0;
            led_data   <= '0;
            led_last   <= 1'b0;
            frame_drop <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            frame_err  <= 1'b0;
            if (w_rise) begin
                if (!w_frame_ok)           frame_err  <= 1'b1;
                else if (r_state != StIdle) frame_drop <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (w_rise && w_frame_ok) begin
                        r_wr_bank <= ~r_wr_bank;
                        r_state   <= StSend;
                        r_rd_addr <= '0;
                        led_valid <= 1'b1;
                        led_data  <= r_mem[r_wr_bank][0];
                        led_last  <= (LAST_ADDR == '0);
                    end
                end
                StSend: begin
                    if (led_ready) begin
                        if (r_rd_addr == LAST_ADDR) begin
                            r_state   <= StGap;
                            r_gap     <= GAP_LOAD;
                            led_valid <= 1'b0;
                            led_last  <= 1'b0;
                        end else begin
                            r_rd_addr <= w_next_addr;
                            led_data  <= r_mem[w_rd_bank][w_next_addr];
                            led_last  <= (w_next_addr == LAST_ADDR);
                        end
                    end
                end
                StGap: begin
                    if (r_gap == '0) r_state <= StIdle;
                    else             r_gap   <= r_gap - GW'(1);
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_led_ring_scheduler.sv
// Directed bench for led_ring_scheduler: a ring-order model of each written frame feeds an
// expected-readout queue that one compare process checks against every valid output cycle.
module tb_led_ring_scheduler;
    localparam int unsigned HOR = 78;
    localparam int unsigned VER = 44;
    localparam int unsigned NZ  = 2 * HOR + 2 * VER;
    localparam int unsigned GAP = 1000;

    logic        clkn = 1'b0;
    logic        reset = 1'b1;
    logic        vs = 1'b1;
    logic        up_dv = 1'b0, down_dv = 1'b0, left_dv = 1'b0, right_dv = 1'b0;
    logic [23:0] up_data = '0, down_data = '0, left_data = '0, right_data = '0;
    logic        led_ready = 1'b0;
    logic        led_valid, led_last, busy, frame_drop, frame_err;
    logic [23:0] led_data;

    int          n_checks = 0;
    int          n_pass = 0;
    int          acc_count = 0;
    int          cnt_err = 0;
    int          cnt_drop = 0;
    logic [23:0] m_ring [NZ];
    logic [23:0] exp_q [$];

    led_ring_scheduler #(
        .NUM_HOR    (HOR),
        .NUM_VER    (VER),
        .GAP_CYCLES (GAP)
    ) dut (
        .clkn       (clkn),
        .reset      (reset),
        .vs         (vs),
        .up_dv      (up_dv),
        .up_data    (up_data),
        .down_dv    (down_dv),
        .down_data  (down_data),
        .left_dv    (left_dv),
        .left_data  (left_data),
        .right_dv   (right_dv),
        .right_data (right_data),
        .led_ready  (led_ready),
        .led_valid  (led_valid),
        .led_data   (led_data),
        .led_last   (led_last),
        .busy       (busy),
        .frame_drop (frame_drop),
        .frame_err  (frame_err)
    );

    always #5 clkn = ~clkn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Inputs change just after the active (falling) edge; outputs are sampled on the rising edge.
    task automatic tick();
        @(negedge clkn);
        #1;
    endtask

    always @(posedge clkn) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (frame_err)  cnt_err++;
            if (frame_drop) cnt_drop++;
            if (led_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(led_valid), 32'd0);
                end else begin
                    check("led_data", 32'(led_data), 32'(exp_q[0]));
                    check("led_last", 32'(led_last), 32'(exp_q.size() == 1));
                    if (led_ready) begin
                        void'(exp_q.pop_front());
                        acc_count++;
                    end
                end
            end
        end
    end

    // Drives one frame; the model keeps only zones within each edge's limit, at ring addresses.
    task automatic send_frame(input int tag, input int nt, input int nr, input int nb,
                              input int nl);
        logic [23:0] tb;
        int          nmax;
        tb   = {4'(tag), 20'h0};
        nmax = nt;
        if (nr > nmax) nmax = nr;
        if (nb > nmax) nmax = nb;
        if (nl > nmax) nmax = nl;
        tick();
        vs = 1'b0;
        for (int i = 0; i < nmax; i++) begin
            tick();
            up_dv      = (i < nt);
            right_dv   = (i < nr);
            down_dv    = (i < nb);
            left_dv    = (i < nl);
            up_data    = tb + 24'h000100 + 24'(i);
            right_data = tb + 24'h020000 + 24'(i);
            down_data  = tb + 24'h030000 + 24'(i);
            left_data  = tb + 24'h040000 + 24'(i);
            if (i < nt && i < HOR) m_ring[i]             = up_data;
            if (i < nr && i < VER) m_ring[HOR + i]       = right_data;
            if (i < nb && i < HOR) m_ring[2*HOR+VER-1-i] = down_data;
            if (i < nl && i < VER) m_ring[NZ-1-i]        = left_data;
        end
        tick();
        up_dv = 1'b0; right_dv = 1'b0; down_dv = 1'b0; left_dv = 1'b0;
        vs = 1'b1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NZ; i++) exp_q.push_back(m_ring[i]);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < NZ * 4 + GAP + 50; k++) begin
            if (!busy && exp_q.size() == 0) break;
            tick();
        end
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        check({name, "_idle_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_run, last_run, gap_run, base, e0, d0;
        logic [3:0] pat;

        // Reset state
        tick(); tick();
        check("rst_led_valid", 32'(led_valid), 32'd0);
        check("rst_led_data", 32'(led_data), 32'd0);
        check("rst_led_last", 32'(led_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_drop", 32'(frame_drop), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        tick(); tick();

        // Full frame, ready held high: 244 back-to-back zones then the latch gap
        send_frame(0, HOR, VER, HOR, VER);
        led_ready = 1'b1;
        push_frame();
        tick();
        valid_run = 0;
        last_run = 0;
        for (int i = 0; i < NZ; i++) begin
            if (led_valid) valid_run++;
            if (led_valid && led_last) last_run++;
            case (i)
                0:   check("t1_z0",   32'(led_data), 32'h000100);
                77:  check("t1_z77",  32'(led_data), 32'h00014D);
                78:  check("t1_z78",  32'(led_data), 32'h020000);
                121: check("t1_z121", 32'(led_data), 32'h02002B);
                122: check("t1_z122", 32'(led_data), 32'h03004D);
                199: check("t1_z199", 32'(led_data), 32'h030000);
                200: check("t1_z200", 32'(led_data), 32'h04002B);
                243: begin
                    check("t1_z243", 32'(led_data), 32'h040000);
                    check("t1_last243", 32'(led_last), 32'd1);
                end
                default: ;
            endcase
            tick();
        end
        check("t1_valid_run", 32'(valid_run), 32'(NZ));
        check("t1_last_count", 32'(last_run), 32'd1);
        check("t1_valid_after", 32'(led_valid), 32'd0);
        gap_run = 0;
        for (int g = 0; g < GAP + 20; g++) begin
            if (!busy) break;
            gap_run++;
            tick();
        end
        check("t1_gap_cycles", 32'(gap_run), 32'(GAP));
        wait_idle("t1");

        // Ready toggling 1,0,0,1
        pat = 4'b1001;
        base = acc_count;
        send_frame(2, HOR, VER, HOR, VER);
        push_frame();
        for (int j = 0; j < NZ * 4 + 20; j++) begin
            led_ready = pat[j % 4];
            if (exp_q.size() == 0) break;
            tick();
        end
        led_ready = 1'b1;
        check("t2_accepts", 32'(acc_count - base), 32'(NZ));
        wait_idle("t2");

        // One left zone missing
        e0 = cnt_err;
        d0 = cnt_drop;
        send_frame(3, HOR, VER, HOR, VER - 1);
        tick();
        check("t3_err_pulse", 32'(frame_err), 32'd1);
        check("t3_valid", 32'(led_valid), 32'd0);
        tick();
        check("t3_err_cleared", 32'(frame_err), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("t3_valid_later", 32'(led_valid), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_err_count", 32'(cnt_err - e0), 32'd1);
        check("t3_no_drop", 32'(cnt_drop - d0), 32'd0);

        // 45 right zones: overflow rejects the frame and nothing is re-sent
        e0 = cnt_err;
        send_frame(4, HOR, VER + 1, HOR, VER);
        tick();
        check("t4_err_pulse", 32'(frame_err), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("t4_valid", 32'(led_valid), 32'd0);
        check("t4_err_count", 32'(cnt_err - e0), 32'd1);

        // Second frame commits during SEND and is dropped; a third after idle is shown
        e0 = cnt_err;
        d0 = cnt_drop;
        led_ready = 1'b0;
        send_frame(5, HOR, VER, HOR, VER);
        push_frame();
        tick();
        check("t5a_first", 32'(led_data), 32'h500100);
        send_frame(6, HOR, VER, HOR, VER);
        tick();
        check("t5_drop_pulse", 32'(frame_drop), 32'd1);
        tick();
        check("t5_drop_cleared", 32'(frame_drop), 32'd0);
        check("t5_drop_count", 32'(cnt_drop - d0), 32'd1);
        check("t5_no_err", 32'(cnt_err - e0), 32'd0);
        check("t5_still_first", 32'(led_data), 32'h500100);
        led_ready = 1'b1;
        wait_idle("t5a");
        send_frame(7, HOR, VER, HOR, VER);
        push_frame();
        tick();
        check("t5c_first", 32'(led_data), 32'h700100);
        wait_idle("t5c");

        // Reset at zone 100 of a readout
        base = acc_count;
        send_frame(8, HOR, VER, HOR, VER);
        push_frame();
        for (int i = 0; i < NZ + 10; i++) begin
            if (acc_count - base >= 100) break;
            tick();
        end
        check("t6_reached_100", 32'(acc_count - base), 32'd100);
        reset = 1'b1;
        #1;
        check("t6_valid_on_reset", 32'(led_valid), 32'd0);
        check("t6_busy_on_reset", 32'(busy), 32'd0);
        tick(); tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6_valid_after", 32'(led_valid), 32'd0);
        send_frame(9, HOR, VER, HOR, VER);
        push_frame();
        tick();
        check("t6_restart_valid", 32'(led_valid), 32'd1);
        check("t6_restart_z0", 32'(led_data), 32'h900100);
        wait_idle("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
